// File: rtl/mem_block_copier.sv
// rtl/mem_block_copier.sv - word-at-a-time block copy initiator for the unified 16-bit memory
// Optional block fill mode is enabled by defining MEM_BLOCK_COPIER_FILL_EN.
module mem_block_copier #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  len,
`ifdef MEM_BLOCK_COPIER_FILL_EN
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_value,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [LEN_WIDTH-1:0]  words_copied,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [ADDR_WIDTH-1:0] MemIn,
  output logic [DATA_WIDTH-1:0] WriteData,
  input  logic [DATA_WIDTH-1:0] MemOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ONE_A = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  ONE_L = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [LEN_WIDTH-1:0]  ZERO_L = '0;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  rem_q, rem_d;
  logic [LEN_WIDTH-1:0]  words_q, words_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  fill_start;
  logic                  fill_active;
  logic [DATA_WIDTH-1:0] fill_data;

`ifdef MEM_BLOCK_COPIER_FILL_EN
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] fval_q, fval_d;

  assign fill_start  = fill;
  assign fill_active = fill_q;
  assign fill_data   = fval_q;
`else
  assign fill_start  = 1'b0;
  assign fill_active = 1'b0;
  assign fill_data   = '0;
`endif

  // Outputs are registered from the next state, so each strobe lines up with its state.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    words_d = words_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef MEM_BLOCK_COPIER_FILL_EN
    fill_d  = fill_q;
    fval_d  = fval_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          words_d = '0;
          if (len != ZERO_L) begin
            src_d   = src_addr;
            dst_d   = dst_addr;
            rem_d   = len;
            addr_d  = src_addr;
            rd_d    = ~fill_start;
            state_d = READ;
`ifdef MEM_BLOCK_COPIER_FILL_EN
            fill_d  = fill;
            fval_d  = fill_value;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      READ: begin
        // In fill mode this cycle is the quiet gap between writes.
        wr_d    = 1'b1;
        addr_d  = dst_q;
        wdata_d = fill_active ? fill_data : MemOut;
        state_d = WRITE;
      end
      WRITE: begin
        src_d   = src_q + ONE_A;
        dst_d   = dst_q + ONE_A;
        words_d = words_q + ONE_L;
        rem_d   = rem_q - ONE_L;
        if (rem_q != ONE_L) begin
          rd_d    = ~fill_active;
          addr_d  = src_q + ONE_A;
          state_d = READ;
        end else begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      words_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef MEM_BLOCK_COPIER_FILL_EN
      fill_q  <= 1'b0;
      fval_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      words_q <= words_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef MEM_BLOCK_COPIER_FILL_EN
      fill_q  <= fill_d;
      fval_q  <= fval_d;
`endif
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign words_copied = words_q;
  assign MemRead      = rd_q;
  assign MemWrite     = wr_q;
  assign MemIn        = addr_q;
  assign WriteData    = wdata_q;

endmodule

// File: tb/tb_mem_block_copier.sv
// tb/tb_mem_block_copier.sv - directed self-checking bench for mem_block_copier
// Define MEM_BLOCK_COPIER_FILL_EN to also exercise fill mode.
`timescale 1ns/1ps
module tb_mem_block_copier;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [7:0]  len;
`ifdef MEM_BLOCK_COPIER_FILL_EN
  logic        fill;
  logic [15:0] fill_value;
`endif
  logic        busy;
  logic        done;
  logic [7:0]  words_copied;
  logic        MemRead;
  logic        MemWrite;
  logic [15:0] MemIn;
  logic [15:0] WriteData;
  logic [15:0] MemOut;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:65535];
  logic        tb_we;
  logic [15:0] tb_waddr;
  logic [15:0] tb_wdata;

  int overlap_cnt = 0;
  int b2b_cnt = 0;
  logic wr_prev = 1'b0;
  logic [15:0] rd_log[$];
  logic [15:0] wr_log[$];

  mem_block_copier #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .LEN_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .src_addr(src_addr),
    .dst_addr(dst_addr),
    .len(len),
`ifdef MEM_BLOCK_COPIER_FILL_EN
    .fill(fill),
    .fill_value(fill_value),
`endif
    .busy(busy),
    .done(done),
    .words_copied(words_copied),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .MemIn(MemIn),
    .WriteData(WriteData),
    .MemOut(MemOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign MemOut = MemRead ? mem[MemIn] : 16'h0000;

  always @(posedge clock) begin
    if (MemWrite) mem[MemIn] <= WriteData;
    if (tb_we) mem[tb_waddr] <= tb_wdata;
  end

  always @(negedge clock) begin
    if (MemRead && MemWrite) overlap_cnt <= overlap_cnt + 1;
    if (MemWrite && wr_prev) b2b_cnt <= b2b_cnt + 1;
    wr_prev <= MemWrite;
    if (MemRead) rd_log.push_back(MemIn);
    if (MemWrite) wr_log.push_back(MemIn);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock);
    tb_we = 1'b1;
    tb_waddr = a;
    tb_wdata = d;
    @(posedge clock);
    #1;
    tb_we = 1'b0;
  endtask

  // Returns the cycle (1 = first cycle after the start edge) in which done was seen.
  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [7:0] n, output int cyc);
    @(negedge clock);
    src_addr = s;
    dst_addr = d;
    len = n;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 100) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    int cyc;
    int r0;
    int w0;
    reset = 1'b1;
    start = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len = '0;
    tb_we = 1'b0;
    tb_waddr = '0;
    tb_wdata = '0;
`ifdef MEM_BLOCK_COPIER_FILL_EN
    fill = 1'b0;
    fill_value = '0;
`endif
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      @(posedge clock);
      #1;
      check("idle_outputs",
            {busy, done, words_copied, MemRead, MemWrite, MemIn, WriteData}, 64'h0);
    end

    poke(16'h0010, 16'hAAAA);
    poke(16'h0011, 16'h1234);
    poke(16'h0012, 16'h0000);
    poke(16'h0013, 16'hFFFF);
    poke(16'h0030, 16'h3030);
    poke(16'hFFFF, 16'hBEEF);
    poke(16'h0000, 16'hC0DE);
    poke(16'h0001, 16'h1111);
    poke(16'h0002, 16'h2222);
    poke(16'h0003, 16'h3333);
    poke(16'h0060, 16'h7777);

    go(16'h0010, 16'h0040, 8'd4, cyc);
    check("copy_latency", cyc, 9);
    check("copy_mem40", mem[16'h0040], 16'hAAAA);
    check("copy_mem41", mem[16'h0041], 16'h1234);
    check("copy_mem42", mem[16'h0042], 16'h0000);
    check("copy_mem43", mem[16'h0043], 16'hFFFF);
    check("copy_words", words_copied, 4);
    check("copy_idle_after", {busy, done, MemRead, MemWrite}, 0);

    r0 = rd_log.size();
    w0 = wr_log.size();
    go(16'h0020, 16'h0030, 8'd0, cyc);
    check("len0_latency", cyc, 1);
    check("len0_reads", rd_log.size() - r0, 0);
    check("len0_writes", wr_log.size() - w0, 0);
    check("len0_mem30", mem[16'h0030], 16'h3030);

    r0 = rd_log.size();
    w0 = wr_log.size();
    go(16'hFFFF, 16'h0001, 8'd3, cyc);
    check("wrap_latency", cyc, 7);
    check("wrap_nreads", rd_log.size() - r0, 3);
    check("wrap_nwrites", wr_log.size() - w0, 3);
    check("wrap_rd0", rd_log[r0], 16'hFFFF);
    check("wrap_rd1", rd_log[r0+1], 16'h0000);
    check("wrap_rd2", rd_log[r0+2], 16'h0001);
    check("wrap_wr0", wr_log[w0], 16'h0001);
    check("wrap_wr1", wr_log[w0+1], 16'h0002);
    check("wrap_wr2", wr_log[w0+2], 16'h0003);
    check("wrap_mem1", mem[16'h0001], 16'hBEEF);
    check("wrap_mem2", mem[16'h0002], 16'hC0DE);
    check("wrap_mem3", mem[16'h0003], 16'hBEEF);

    // Reset during the third write of an 8-word copy.
    @(negedge clock);
    src_addr = 16'h0010;
    dst_addr = 16'h0100;
    len = 8'd8;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    check("mid_in_write3", {busy, MemWrite, MemRead}, 3'b110);
    check("mid_words_before", words_copied, 2);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("mid_reset_outputs",
          {busy, done, words_copied, MemRead, MemWrite, MemIn, WriteData}, 64'h0);
    @(posedge clock);
    #1;
    check("mid_reset_stays_idle", {busy, MemRead, MemWrite}, 0);

    // len=1 copy, with a second start pulsed while busy.
    @(negedge clock);
    src_addr = 16'h0010;
    dst_addr = 16'h0050;
    len = 8'd1;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("one_busy_c1", {busy, MemRead, MemIn}, {2'b11, 16'h0010});
    @(negedge clock);
    src_addr = 16'h0011;
    dst_addr = 16'h0060;
    len = 8'd5;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    check("one_write_c2", {MemWrite, MemIn, WriteData}, {1'b1, 16'h0050, 16'hAAAA});
    @(posedge clock);
    #1;
    check("one_done_c3", {busy, done, words_copied}, {2'b11, 8'd1});
    @(posedge clock);
    #1;
    check("one_idle_after", {busy, done}, 0);
    @(posedge clock);
    #1;
    check("busy_start_not_queued", {busy, MemRead, MemWrite}, 0);
    check("one_mem50", mem[16'h0050], 16'hAAAA);
    check("busy_start_mem60", mem[16'h0060], 16'h7777);
    check("busy_start_words", words_copied, 1);

`ifdef MEM_BLOCK_COPIER_FILL_EN
    r0 = rd_log.size();
    w0 = wr_log.size();
    fill = 1'b1;
    fill_value = 16'h5A5A;
    go(16'h0010, 16'h0080, 8'd3, cyc);
    fill = 1'b0;
    check("fill_latency", cyc, 7);
    check("fill_reads", rd_log.size() - r0, 0);
    check("fill_writes", wr_log.size() - w0, 3);
    check("fill_mem80", mem[16'h0080], 16'h5A5A);
    check("fill_mem81", mem[16'h0081], 16'h5A5A);
    check("fill_mem82", mem[16'h0082], 16'h5A5A);
    check("fill_words", words_copied, 3);
`endif

    check("strobe_overlap", overlap_cnt, 0);
    check("write_back_to_back", b2b_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
